// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative unsigned multiply/divide beside the EX-stage ALU.
// It owns the HI/LO pair. MULTU and DIVU each take one bit per cycle.
// MTHI and MTLO write HI or LO directly, and HI/LO are always visible for MFHI/MFLO.
//
// Handshake: start is a single-cycle request, qualified by funct, and it is
// only accepted while the FSM is IDLE; a start seen in RUN or FIN is dropped.
// busy is high for the whole RUN phase. done is a one-cycle pulse in the cycle
// where hi/lo first show the new result.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [5:0]       F_MTHI  = 6'd17;
    localparam logic [5:0]       F_MTLO  = 6'd19;
    localparam logic [5:0]       F_MULTU = 6'd25;
    localparam logic [5:0]       F_DIVU  = 6'd27;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    state_t state;
    logic [CNT_W-1:0] count;
    logic             is_div;

    // Working registers shared by both algorithms.
    //   multiply: work_hi = partial-product accumulator,
    //             work_lo = multiplier being shifted out,
    //             operand = multiplicand.
    //   divide:   work_hi = partial remainder,
    //             work_lo = dividend shifting out / quotient shifting in,
    //             operand = divisor.
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [WIDTH-1:0] operand;

    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    // A zero divisor never borrows, so it naturally yields quotient = all ones
    // and remainder = dividend.
    always_comb begin
        add_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
        shifted = {work_hi, work_lo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        next_hi = add_sum[WIDTH:1];
        next_lo = {add_sum[0], work_lo[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                next_hi = diff[WIDTH-1:0];
                next_lo = {work_lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {work_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Control FSM with registered busy/done and HI/LO update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            is_div  <= 1'b0;
            work_hi <= '0;
            work_lo <= '0;
            operand <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        case (funct)
                            F_MULTU: begin
                                work_hi <= '0;
                                work_lo <= src_b;
                                operand <= src_a;
                                is_div  <= 1'b0;
                                count   <= '0;
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
                            F_DIVU: begin
                                work_hi <= '0;
                                work_lo <= src_a;
                                operand <= src_b;
                                is_div  <= 1'b1;
                                count   <= '0;
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
                            F_MTHI: begin
                                hi    <= src_a;
                                done  <= 1'b1;
                                state <= FIN;
                            end
                            F_MTLO: begin
                                lo    <= src_a;
                                done  <= 1'b1;
                                state <= FIN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    work_hi <= next_hi;
                    work_lo <= next_lo;
                    count   <= count + CNT_W'(1);
                    if (count == LAST) begin
                        hi    <= next_hi;
                        lo    <= next_lo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: drives an 8-bit and a 32-bit instance.
// Expected HI/LO pairs are queued at issue time and popped by monitors on done.
module tb_hilo_muldiv_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start8, busy8, done8;
    logic [5:0]  funct8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        start32, busy32, done32;
    logic [5:0]  funct32;
    logic [31:0] a32, b32, hi32, lo32;

    hilo_muldiv_unit #(.WIDTH(8), .CNT_W(4)) u8 (
        .clk(clk), .rst(rst), .start(start8), .funct(funct8), .src_a(a8), .src_b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) u32 (
        .clk(clk), .rst(rst), .start(start32), .funct(funct32), .src_a(a32), .src_b(b32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp8_q[$];
    logic [63:0] exp32_q[$];

    // Reference HI/LO contents as the architecture defines them.
    logic [7:0]  m_hi8, m_lo8;
    logic [31:0] m_hi32, m_lo32;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitors.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (exp8_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done8: got done=1 with hi=%0h lo=%0h, required no done", hi8, lo8);
            end else begin
                check("result8", {48'd0, hi8, lo8}, {48'd0, exp8_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (done32 === 1'b1) begin
            if (exp32_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done32: got done=1 with hi=%0h lo=%0h, required no done", hi32, lo32);
            end else begin
                check("result32", {hi32, lo32}, exp32_q.pop_front());
            end
        end
    end

    function automatic logic get_busy(input bit big);
        return big ? busy32 : busy8;
    endfunction

    function automatic logic get_done(input bit big);
        return big ? done32 : done8;
    endfunction

    // Update the reference model and queue the expected pair.
    task automatic model(input bit big, input logic [5:0] f, input logic [63:0] a, input logic [63:0] b);
        if (big) begin
            case (f)
                6'd25: {m_hi32, m_lo32} = {32'd0, a[31:0]} * {32'd0, b[31:0]};
                6'd27: begin
                    if (b[31:0] == 0) begin
                        m_lo32 = '1;
                        m_hi32 = a[31:0];
                    end else begin
                        m_lo32 = a[31:0] / b[31:0];
                        m_hi32 = a[31:0] % b[31:0];
                    end
                end
                6'd17: m_hi32 = a[31:0];
                6'd19: m_lo32 = a[31:0];
                default: ;
            endcase
            if (f == 25 || f == 27 || f == 17 || f == 19) exp32_q.push_back({m_hi32, m_lo32});
        end else begin
            case (f)
                6'd25: {m_hi8, m_lo8} = {8'd0, a[7:0]} * {8'd0, b[7:0]};
                6'd27: begin
                    if (b[7:0] == 0) begin
                        m_lo8 = '1;
                        m_hi8 = a[7:0];
                    end else begin
                        m_lo8 = a[7:0] / b[7:0];
                        m_hi8 = a[7:0] % b[7:0];
                    end
                end
                6'd17: m_hi8 = a[7:0];
                6'd19: m_lo8 = a[7:0];
                default: ;
            endcase
            if (f == 25 || f == 27 || f == 17 || f == 19) exp8_q.push_back({m_hi8, m_lo8});
        end
    endtask

    task automatic drive(input bit big, input logic s, input logic [5:0] f,
                         input logic [63:0] a, input logic [63:0] b);
        if (big) begin
            start32 = s; funct32 = f; a32 = a[31:0]; b32 = b[31:0];
        end else begin
            start8 = s; funct8 = f; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Issue one op from IDLE and wait (bounded) for its done pulse.
    task automatic op(input bit big, input logic [5:0] f, input logic [63:0] a, input logic [63:0] b);
        int  w;
        int  lat;
        bit  iter;
        bit  known;
        bit  busy_ok;
        bit  quiet_ok;
        w     = big ? 32 : 8;
        iter  = (f == 25 || f == 27);
        known = iter || f == 17 || f == 19;
        model(big, f, a, b);
        @(posedge clk); #1;
        drive(big, 1'b1, f, a, b);
        @(posedge clk); #1;
        // Scramble operands right after acceptance; they must already be latched.
        drive(big, 1'b0, 6'd0, rnd64(), rnd64());
        if (known) begin
            busy_ok = 1'b1;
            lat = 0;
            while (lat < w + 5) begin
                @(negedge clk);
                if (get_done(big)) break;
                if (iter && lat < w && get_busy(big) !== 1'b1) busy_ok = 1'b0;
                lat++;
            end
            check(big ? "latency32" : "latency8", 64'(lat), iter ? 64'(w) : 64'd0);
            if (iter) check(big ? "busy_run32" : "busy_run8", 64'(busy_ok), 64'd1);
            @(posedge clk);
        end else begin
            quiet_ok = 1'b1;
            repeat (w + 3) begin
                @(negedge clk);
                if (get_busy(big) !== 1'b0 || get_done(big) !== 1'b0) quiet_ok = 1'b0;
            end
            check("bad_funct_quiet", 64'(quiet_ok), 64'd1);
            if (big) check("bad_funct_hilo32", {hi32, lo32}, {m_hi32, m_lo32});
            else     check("bad_funct_hilo8", {48'd0, hi8, lo8}, {48'd0, m_hi8, m_lo8});
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        m_hi8 = '0; m_lo8 = '0; m_hi32 = '0; m_lo32 = '0;
        exp8_q.delete();
        exp32_q.delete();
    endtask

    initial begin
        int dones;
        logic [5:0] f;
        logic [63:0] a, b;
        rst = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 6'd0, 64'd0, 64'd0);
        m_hi8 = '0; m_lo8 = '0; m_hi32 = '0; m_lo32 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy8", 64'(busy8), 64'd0);
        check("reset_done8", 64'(done8), 64'd0);
        check("reset_hilo8", {48'd0, hi8, lo8}, 64'd0);
        check("reset_busy32", 64'(busy32), 64'd0);
        check("reset_hilo32", {hi32, lo32}, 64'd0);

        // Directed 32-bit cases with known answers.
        op(1'b1, 6'd25, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        check("mul_max_hi32", 64'(hi32), 64'hFFFF_FFFE);
        check("mul_max_lo32", 64'(lo32), 64'h1);
        op(1'b1, 6'd27, 64'd100, 64'd7);
        check("div_100_7_lo", 64'(lo32), 64'd14);
        check("div_100_7_hi", 64'(hi32), 64'd2);
        op(1'b1, 6'd27, 64'd5, 64'd0);
        check("div_by0_lo", 64'(lo32), 64'hFFFF_FFFF);
        check("div_by0_hi", 64'(hi32), 64'd5);
        op(1'b1, 6'd17, 64'h1234, 64'd0);
        op(1'b1, 6'd19, 64'hABCD, 64'd0);
        check("mthi_hi32", 64'(hi32), 64'h1234);
        check("mtlo_lo32", 64'(lo32), 64'hABCD);

        // Unrecognised funct: no action.
        op(1'b0, 6'd32, 64'h5A, 64'hA5);

        // DIVU pulsed mid-RUN of a MULTU is dropped.
        model(1'b0, 6'd25, 64'd13, 64'd11);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 6'd25, 64'd13, 64'd11);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1 drive(1'b0, 1'b1, 6'd27, 64'd200, 64'd3);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check("midrun_single_done", 64'(dones), 64'd1);
        check("midrun_mul_result", {48'd0, hi8, lo8}, 64'd143);

        // Reset in the middle of RUN discards the op.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 6'd25, 64'hFF, 64'hFF);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi8 = '0; m_lo8 = '0; m_hi32 = '0; m_lo32 = '0;
        @(negedge clk);
        check("rst_run_busy", 64'(busy8), 64'd0);
        check("rst_run_done", 64'(done8), 64'd0);
        check("rst_run_hilo", {48'd0, hi8, lo8}, 64'd0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check("rst_run_no_done", 64'(dones), 64'd0);

        // Reset and start at the same edge: reset wins.
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b1, 6'd25, 64'd9, 64'd9);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 6'd0, 64'd0, 64'd0);
        @(negedge clk);
        check("rst_start_busy", 64'(busy8), 64'd0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check("rst_start_no_done", 64'(dones), 64'd0);

        // Random 8-bit MULTU/DIVU, including zero divisors.
        repeat (300) begin
            f = ($urandom_range(0, 1) == 0) ? 6'd25 : 6'd27;
            a = 64'($urandom_range(0, 255));
            b = ($urandom_range(0, 9) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
            op(1'b0, f, a, b);
        end

        // Random 32-bit mix including MTHI/MTLO.
        repeat (40) begin
            case ($urandom_range(0, 3))
                0: f = 6'd25;
                1: f = 6'd27;
                2: f = 6'd17;
                default: f = 6'd19;
            endcase
            a = 64'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom >> $urandom_range(0, 31));
            op(1'b1, f, a, b);
        end

        repeat (4) @(negedge clk);
        check("queue8_drained", 64'(exp8_q.size()), 64'd0);
        check("queue32_drained", 64'(exp32_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
